// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int unsigned MC_READ    = 0;
   localparam int unsigned MC_WRITE   = 1;
   localparam int unsigned MC_SIZE_LO = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      StIdle,
      StWait
   } state_e;

   // lanes holds the addressed bytes already shifted down to bit 0
   function automatic logic [31:0] load_extend(input logic [31:0] lanes, input size_e size,
                                               input logic zext);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {{24{~zext & lanes[7]}}, lanes[7:0]};
         SZ_HALF: r = {{16{~zext & lanes[15]}}, lanes[15:0]};
         default: r = lanes;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory stage.
interface mem_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned WB_W   = 2
);
   logic              In_Valid;
   logic [ADDR_W-1:0] In_Address;
   logic [31:0]       In_Data;
   logic [3:0]        In_MEMControl;
   logic              In_LoadUnsigned;
   logic [WB_W-1:0]   In_WBControl;
   logic              Out_Valid;
   logic [ADDR_W-1:0] Out_Address;
   logic [31:0]       Out_Data;
   logic [WB_W-1:0]   Out_WBControl;
   logic              Out_Fault;
   logic              Out_Stall;

   modport master (
      output In_Valid, In_Address, In_Data, In_MEMControl, In_LoadUnsigned, In_WBControl,
      input  Out_Valid, Out_Address, Out_Data, Out_WBControl, Out_Fault, Out_Stall
   );

   modport slave (
      input  In_Valid, In_Address, In_Data, In_MEMControl, In_LoadUnsigned, In_WBControl,
      output Out_Valid, Out_Address, Out_Data, Out_WBControl, Out_Fault, Out_Stall
   );
endinterface

// File: rtl/mem_stage_dmem.sv
// Data memory: DEPTH x 32 with per-byte write enables, synchronous write, async read.
module mem_stage_dmem #(
   parameter int unsigned DEPTH = 256
) (
   input  logic                     Clk,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [3:0]               be,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores with optional
// wait states; outputs form the MEM/WB pipeline register.
module mem_stage #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned WB_W   = 2,
   parameter int unsigned LAT    = 0
) (
   input logic        Clk,
   input logic        Rst_n,
   mem_stage_if.slave bus
);
   import mem_stage_pkg::*;

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT);

   logic             rd, wr, zext, mem_op, fault, access, stall, commit;
   logic             misalign, bad_size, out_of_range;
   size_e            size;
   logic [1:0]       lane;
   logic [IDX_W-1:0] idx;
   logic [3:0]       be;
   logic [31:0]      wdata, rdata, rlanes;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, fault_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]      data_q;
   logic [WB_W-1:0]  wb_q;

   assign rd     = bus.In_MEMControl[MC_READ];
   assign wr     = bus.In_MEMControl[MC_WRITE];
   assign size   = size_e'(bus.In_MEMControl[MC_SIZE_LO +: 2]);
   assign zext   = bus.In_LoadUnsigned;
   assign lane   = bus.In_Address[1:0];
   assign idx    = bus.In_Address[IDX_W+1:2];
   assign mem_op = bus.In_Valid & (rd | wr);

   always_comb begin
      misalign = 1'b0;
      bad_size = 1'b0;
      case (size)
         SZ_HALF: misalign = lane[0];
         SZ_WORD: misalign = (lane != 2'b00);
         SZ_RSVD: bad_size = 1'b1;
         default: ;
      endcase
   end

   assign out_of_range = (bus.In_Address >> (IDX_W + 2)) != '0;
   assign fault  = mem_op & ((rd & wr) | bad_size | misalign | out_of_range);
   assign access = mem_op & ~fault;

   // cnt counts wait states already served; the access commits when it reaches LAT
   always_comb begin
      state_d = StIdle;
      cnt_d   = '0;
      stall   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         StIdle: if (access) begin
            if (LAT == 0) begin
               commit = 1'b1;
            end else begin
               stall   = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = StWait;
            end
         end
         StWait: if (access) begin
            if (cnt_q == CNT_MAX) begin
               commit = 1'b1;
            end else begin
               stall   = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = StWait;
            end
         end
      endcase
   end

   always_comb begin
      be    = 4'b0000;
      wdata = bus.In_Data;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wdata = {4{bus.In_Data[7:0]}};
         end
         SZ_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.In_Data[15:0]}};
         end
         default: be = 4'b1111;
      endcase
      if (!(commit && wr)) be = 4'b0000;
   end

   mem_stage_dmem #(
      .DEPTH(DEPTH)
   ) u_dmem (
      .Clk  (Clk),
      .addr (idx),
      .be   (be),
      .wdata(wdata),
      .rdata(rdata)
   );

   assign rlanes = rdata >> {lane, 3'b000};

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         wb_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= bus.In_Valid & ~stall;
         addr_q  <= bus.In_Address;
         data_q  <= (commit && rd) ? load_extend(rlanes, size, zext) : 32'h0;
         wb_q    <= fault ? '0 : bus.In_WBControl;
         fault_q <= fault;
      end
   end

   assign bus.Out_Valid     = valid_q;
   assign bus.Out_Address   = addr_q;
   assign bus.Out_Data      = data_q;
   assign bus.Out_WBControl = wb_q;
   assign bus.Out_Fault     = fault_q;
   assign bus.Out_Stall     = stall;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: three instances (LAT 0, 2, 3) against a
// byte-level memory model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned DEPTH = 256;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  wb;
      logic        f;
      logic        st;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model [3][DEPTH];

   always #5 clk = ~clk;

   mem_stage_if #(.ADDR_W(32), .WB_W(2)) bus0 ();
   mem_stage_if #(.ADDR_W(32), .WB_W(2)) bus2 ();
   mem_stage_if #(.ADDR_W(32), .WB_W(2)) bus3 ();

   mem_stage #(.DEPTH(DEPTH), .ADDR_W(32), .WB_W(2), .LAT(0))
      u0 (.Clk(clk), .Rst_n(rst_n), .bus(bus0));
   mem_stage #(.DEPTH(DEPTH), .ADDR_W(32), .WB_W(2), .LAT(2))
      u2 (.Clk(clk), .Rst_n(rst_n), .bus(bus2));
   mem_stage #(.DEPTH(DEPTH), .ADDR_W(32), .WB_W(2), .LAT(3))
      u3 (.Clk(clk), .Rst_n(rst_n), .bus(bus3));

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int d, input logic v, input logic [31:0] a,
                         input logic [31:0] dt, input logic [3:0] mc, input logic lu,
                         input logic [1:0] wb);
      case (d)
         0: begin
            bus0.In_Valid = v; bus0.In_Address = a; bus0.In_Data = dt;
            bus0.In_MEMControl = mc; bus0.In_LoadUnsigned = lu; bus0.In_WBControl = wb;
         end
         1: begin
            bus2.In_Valid = v; bus2.In_Address = a; bus2.In_Data = dt;
            bus2.In_MEMControl = mc; bus2.In_LoadUnsigned = lu; bus2.In_WBControl = wb;
         end
         default: begin
            bus3.In_Valid = v; bus3.In_Address = a; bus3.In_Data = dt;
            bus3.In_MEMControl = mc; bus3.In_LoadUnsigned = lu; bus3.In_WBControl = wb;
         end
      endcase
   endtask

   function automatic obs_t get_out(input int d);
      obs_t o;
      case (d)
         0: o = {bus0.Out_Valid, bus0.Out_Address, bus0.Out_Data, bus0.Out_WBControl,
                 bus0.Out_Fault, bus0.Out_Stall};
         1: o = {bus2.Out_Valid, bus2.Out_Address, bus2.Out_Data, bus2.Out_WBControl,
                 bus2.Out_Fault, bus2.Out_Stall};
         default: o = {bus3.Out_Valid, bus3.Out_Address, bus3.Out_Data, bus3.Out_WBControl,
                       bus3.Out_Fault, bus3.Out_Stall};
      endcase
      return o;
   endfunction

   task automatic idle(input int d);
      set_in(d, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that registers the result.
   task automatic do_op(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic lu, input logic [31:0] a, input logic [31:0] dt,
                        input logic [1:0] wb, output logic [31:0] got);
      logic        flt;
      logic [31:0] exp_d, mask;
      int          lane, nb, idx, waits;
      obs_t        o;
      lane  = int'(a % 4);
      nb    = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
      flt   = (rd || wr) && ((rd && wr) || sz == 2'd3 || (sz == 2'd1 && (lane % 2) != 0) ||
                             (sz == 2'd2 && lane != 0) || (a / 4) >= DEPTH);
      idx   = flt ? 0 : int'(a / 4);
      exp_d = 32'h0;
      if (!flt && rd) begin
         mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
         exp_d = (model[d][idx] >> (8 * lane)) & mask;
         if (!lu && nb < 4 && exp_d[8*nb-1]) exp_d = exp_d | ~mask;
      end
      waits = ((rd || wr) && !flt) ? lat_of(d) : 0;
      set_in(d, 1'b1, a, dt, {sz, wr, rd}, lu, wb);
      #1;
      for (int k = 0; k < waits; k++) begin
         o = get_out(d);
         check("stall_high", 32'(o.st), 32'd1);
         @(posedge clk); #1;
         o = get_out(d);
         check("bubble_valid", 32'(o.v), 32'd0);
      end
      o = get_out(d);
      check("stall_low", 32'(o.st), 32'd0);
      @(posedge clk); #1;
      o = get_out(d);
      check("out_valid", 32'(o.v), 32'd1);
      check("out_address", o.a, a);
      check("out_data", o.d, exp_d);
      check("out_wb", 32'(o.wb), flt ? 32'd0 : 32'(wb));
      check("out_fault", 32'(o.f), 32'(flt));
      got = o.d;
      if (!flt && wr) begin
         for (int b = 0; b < nb; b++) model[d][idx][8*(lane+b) +: 8] = dt[8*b +: 8];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [31:0] got, old;
      obs_t o;
      for (int d = 0; d < 3; d++) idle(d);
      #1;
      for (int d = 0; d < 3; d++) begin
         o = get_out(d);
         check("rst_valid", 32'(o.v), 32'd0);
         check("rst_address", o.a, 32'h0);
         check("rst_data", o.d, 32'h0);
         check("rst_wb", 32'(o.wb), 32'd0);
         check("rst_fault", 32'(o.f), 32'd0);
      end
      // Stall is combinational from the inputs with cnt cleared
      set_in(1, 1'b1, 32'h10, 32'h0, {SZ_WORD, 1'b0, 1'b1}, 1'b0, 2'b00);
      set_in(0, 1'b1, 32'h10, 32'h0, {SZ_WORD, 1'b0, 1'b1}, 1'b0, 2'b00);
      #1;
      o = get_out(1); check("rst_stall_lat2", 32'(o.st), 32'd1);
      o = get_out(0); check("rst_stall_lat0", 32'(o.st), 32'd0);
      idle(0); idle(1);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 16; w++)
            do_op(d, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'(4 * w), 32'h0, 2'b00, got);
         idle(d);
      end

      // LAT=0 directed
      do_op(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, 2'b01, got);
      do_op(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 2'b01, got);
      check("tp_word_load", got, 32'hDEAD_BEEF);
      do_op(0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000_0080, 2'b01, got);
      do_op(0, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, 2'b01, got);
      check("tp_byte_signed", got, 32'hFFFF_FF80);
      do_op(0, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0, 2'b01, got);
      check("tp_byte_unsigned", got, 32'h0000_0080);
      do_op(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 2'b01, got);
      check("tp_word_after_byte", got, 32'h0000_8000);
      do_op(0, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 2'b11, got);
      check("tp_misaligned_half", got, 32'h0);
      do_op(0, 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h3, 32'h0, 2'b11, got);
      do_op(0, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h3, 32'hFFFF_FFFF, 2'b11, got);
      do_op(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h1234_5678, 2'b10, got);
      do_op(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 2'b10, got);
      check("tp_word0_unchanged", got, 32'h0);
      idle(0);

      // LAT=2: stall window, then a non-mem op in one cycle, then store->load forwarding
      do_op(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 2'b01, got);
      do_op(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h1234, 32'h5555_5555, 2'b10, got);
      do_op(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFE_F00D, 2'b01, got);
      do_op(1, 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, 2'b01, got);
      check("tp_lat2_half_hi", got, 32'h0000_CAFE);

      // Upstream drops In_Valid mid-wait: nothing commits, counter restarts
      set_in(1, 1'b1, 32'h14, 32'h0, {SZ_WORD, 1'b0, 1'b1}, 1'b0, 2'b01);
      @(posedge clk); #1;
      idle(1); #1;
      o = get_out(1); check("drop_stall", 32'(o.st), 32'd0);
      @(posedge clk); #1;
      o = get_out(1); check("drop_valid", 32'(o.v), 32'd0);
      do_op(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 2'b01, got);
      idle(1);

      // LAT=3: reset during cycle 2 of a store drops it
      old = model[2][3];
      set_in(2, 1'b1, 32'hC, 32'h1234_5678, {SZ_WORD, 1'b1, 1'b0}, 1'b0, 2'b01);
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      o = get_out(2);
      check("midrst_valid", 32'(o.v), 32'd0);
      check("midrst_data", o.d, 32'h0);
      check("midrst_fault", 32'(o.f), 32'd0);
      check("midrst_stall", 32'(o.st), 32'd1);
      idle(2);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      o = get_out(2); check("midrst_no_output", 32'(o.v), 32'd0);
      do_op(2, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, 2'b01, got);
      check("midrst_old_value", got, old);
      idle(2);

      // Randomized ops against the byte model
      for (int n = 0; n < 150; n++) begin
         int          d, kind, r;
         logic        rd, wr;
         logic [1:0]  sz;
         logic [31:0] a;
         d    = int'($urandom_range(0, 2));
         kind = int'($urandom_range(0, 9));
         rd   = (kind == 1) || (kind >= 2 && kind <= 5);
         wr   = (kind == 1) || (kind >= 6);
         sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (kind == 0 && sz == 2'd3) sz = 2'd0;
         r    = int'($urandom_range(0, 9));
         if (r == 0) a = 32'h400 + 32'($urandom_range(0, 255));
         else if (r == 1) a = $urandom | 32'h8000_0000;
         else a = 32'($urandom_range(0, 63));
         do_op(d, rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
               2'($urandom_range(0, 3)), got);
         if ($urandom_range(0, 3) == 0) begin
            idle(d);
            @(posedge clk); #1;
         end
         idle(d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
